hex_color_entry: RTL and testbench



---
 rtl/hex_color_pkg.sv | 16 +
 rtl/SevenSegmentDisplayDecoder.sv | 31 +++
 rtl/button_debounce.sv | 47 ++++
 rtl/hex_color_entry.sv | 147 ++++++++++++++
 tb/tb_hex_color_entry.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/hex_color_pkg.sv
// Shared types and constants for the hex colour entry block.
package hex_color_pkg;

  typedef enum logic [1:0] {
    ST_VIEW   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Cursor position, 5 = most significant nibble (R high), 0 = B low.
  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t CURSOR_TOP = 3'd5;
  localparam logic [6:0] BLANK_SEG  = 7'h7F;

endpackage

// File: rtl/SevenSegmentDisplayDecoder.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module SevenSegmentDisplayDecoder (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Pure lookup, no state.
  always_comb begin
    o_seg = 7'h7F;
    case (i_nibble)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/button_debounce.sv
// Raw active-low pushbutton -> synchronised, debounced level -> one-cycle press pulse.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;

  // Two-flop synchroniser; idles released (high).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_key_n};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // pulse once on an accepted 1->0, so a held key never repeats.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_press <= ~r_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/hex_color_entry.sv
// Six-digit hex colour entry with 7-seg readout, blinking cursor and VGA swatch overlay.
module hex_color_entry
  import hex_color_pkg::*;
#(
  parameter int unsigned BOX_X0          = 208,
  parameter int unsigned BOX_Y0          = 128,
  parameter int unsigned BOX_X1          = 432,
  parameter int unsigned BOX_Y1          = 352,
  parameter int unsigned BLINK_FRAMES    = 30,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  SW,
  input  logic        KEY_EDIT_N,
  input  logic        KEY_NEXT_N,
  input  logic [10:0] X,
  input  logic [10:0] Y,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic [23:0] COLOR,
  output logic        EDITING,
  output logic [41:0] HEX
);

  logic        w_edit_p, w_next_p;
  state_t      r_state, w_state_nxt;
  logic        w_load, w_write, w_commit;
  logic [23:0] r_color, r_buf;
  digit_idx_t  r_cursor;
  logic [7:0]  r_frame;
  logic        r_blink;
  logic        w_tick;
  logic [23:0] w_src;
  logic [23:0] r_pix;
  logic        w_in_box;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_edit (
    .i_clk(CLK), .i_rst_n(RST_N), .i_key_n(KEY_EDIT_N), .o_press(w_edit_p)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .i_clk(CLK), .i_rst_n(RST_N), .i_key_n(KEY_NEXT_N), .o_press(w_next_p)
  );

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_VIEW;
    else        r_state <= w_state_nxt;
  end

  // Next state and datapath strobes; abort beats a same-cycle NEXT, COMMIT drops presses.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_write     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_VIEW: begin
        if (w_edit_p) begin
          w_load      = 1'b1;
          w_state_nxt = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (w_edit_p) begin
          w_state_nxt = ST_VIEW;
        end else if (w_next_p) begin
          w_write = 1'b1;
          if (r_cursor == 3'd0) w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_VIEW;
      end
      default: w_state_nxt = ST_VIEW;
    endcase
  end

  // Edit buffer, cursor and committed colour.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_buf    <= '0;
      r_cursor <= CURSOR_TOP;
      r_color  <= '0;
    end else begin
      if (w_load) begin
        r_buf    <= r_color;
        r_cursor <= CURSOR_TOP;
      end else if (w_write) begin
        r_buf[{r_cursor, 2'b00} +: 4] <= SW;
        if (r_cursor != 3'd0) r_cursor <= r_cursor - 3'd1;
      end
      if (w_commit) r_color <= r_buf;
    end
  end

  assign w_tick = (X == 11'd0) && (Y == 11'd0);

  // Frame counter and blink phase; restarted "on" whenever editing begins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_frame <= '0;
      r_blink <= 1'b1;
    end else if (w_load) begin
      r_frame <= '0;
      r_blink <= 1'b1;
    end else if (w_tick) begin
      if (r_frame == 8'(BLINK_FRAMES - 1)) begin
        r_frame <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_frame <= r_frame + 8'd1;
      end
    end
  end

  assign w_src = (r_state == ST_EDIT) ? r_buf : r_color;

  // Per-digit decode; the cursor digit goes dark during the off half of the blink.
  for (genvar g = 0; g < 6; g++) begin : g_dig
    logic [6:0] w_seg;
    SevenSegmentDisplayDecoder u_dec (.i_nibble(w_src[g*4 +: 4]), .o_seg(w_seg));
    assign HEX[g*7 +: 7] = ((r_state == ST_EDIT) && !r_blink && (r_cursor == 3'(g)))
                           ? BLANK_SEG : w_seg;
  end

  assign w_in_box = (X >= 11'(BOX_X0)) && (X < 11'(BOX_X1)) &&
                    (Y >= 11'(BOX_Y0)) && (Y < 11'(BOX_Y1));

  // One-stage pixel pipe: swatch of committed colour inside the box, pass-through outside.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        r_pix <= '0;
    else if (w_in_box) r_pix <= r_color;
    else               r_pix <= {iR, iG, iB};
  end

  assign {oR, oG, oB} = r_pix;
  assign COLOR        = r_color;
  assign EDITING      = (r_state == ST_EDIT);

endmodule

// File: tb/tb_hex_color_entry.sv
// Directed bench for hex_color_entry with a short debounce window.
module tb_hex_color_entry;

  localparam int DB = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  SW;
  logic        KEY_EDIT_N, KEY_NEXT_N;
  logic [10:0] X, Y;
  logic [7:0]  iR, iG, iB, oR, oG, oB;
  logic [23:0] COLOR;
  logic        EDITING;
  logic [41:0] HEX;

  int n_tests = 0;
  int n_fail  = 0;

  hex_color_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK(CLK), .RST_N(RST_N), .SW(SW), .KEY_EDIT_N(KEY_EDIT_N), .KEY_NEXT_N(KEY_NEXT_N),
    .X(X), .Y(Y), .iR(iR), .iG(iG), .iB(iB), .oR(oR), .oG(oG), .oB(oB),
    .COLOR(COLOR), .EDITING(EDITING), .HEX(HEX)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press one or both keys long enough to be accepted, then release and settle.
  task automatic press(input bit e, input bit n);
    @(negedge CLK);
    if (e) KEY_EDIT_N = 1'b0;
    if (n) KEY_NEXT_N = 1'b0;
    repeat (DB + 6) @(negedge CLK);
    KEY_EDIT_N = 1'b1;
    KEY_NEXT_N = 1'b1;
    repeat (DB + 6) @(negedge CLK);
  endtask

  task automatic pix(input string tag, input int x, input int y,
                     input logic [23:0] rgb, input logic [23:0] exp);
    @(negedge CLK);
    X = 11'(x); Y = 11'(y); {iR, iG, iB} = rgb;
    @(posedge CLK);
    #1 chk(tag, {oR, oG, oB}, exp);
    @(negedge CLK);
    X = 11'd10; Y = 11'd10;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK); X = 11'd0; Y = 11'd0;
      @(negedge CLK); X = 11'd10; Y = 11'd10;
    end
  endtask

  initial begin
    RST_N = 1'b0; SW = 4'h0; KEY_EDIT_N = 1'b1; KEY_NEXT_N = 1'b1;
    X = 11'd10; Y = 11'd10; {iR, iG, iB} = 24'h0;
    repeat (3) @(negedge CLK);
    chk("rst_color", COLOR, 24'h0);
    chk("rst_hex", HEX, {6{7'h40}});
    chk("rst_oRGB", {oR, oG, oB}, 24'h0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // 1: idle after reset
    chk("t1_color", COLOR, 24'h0);
    chk("t1_hex", HEX, {6{7'h40}});
    chk("t1_editing", EDITING, 1'b0);
    pix("t1_in_box", 300, 200, 24'hABCDEF, 24'h000000);
    pix("t1_outside", 10, 10, 24'h123456, 24'h123456);

    // 2: enter 123456
    press(1, 0);
    chk("t2_editing", EDITING, 1'b1);
    chk("t2_hex_start", HEX, {6{7'h40}});
    SW = 4'h1; press(0, 1);
    chk("t2_hex_d5", HEX, {7'h79, {5{7'h40}}});
    for (int d = 2; d <= 6; d++) begin
      SW = 4'(d); press(0, 1);
    end
    chk("t2_editing_off", EDITING, 1'b0);
    chk("t2_color", COLOR, 24'h123456);
    chk("t2_hex", HEX, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    pix("t2_corner_in", 208, 128, 24'hFFFFFF, 24'h123456);
    pix("t2_last_in", 431, 351, 24'h000000, 24'h123456);
    pix("t2_corner_out", 432, 352, 24'h0A0B0C, 24'h0A0B0C);
    pix("t2_left_out", 207, 200, 24'h0D0E0F, 24'h0D0E0F);

    // 3: abort after one digit
    press(1, 0);
    chk("t3_editing", EDITING, 1'b1);
    SW = 4'hF; press(0, 1);
    chk("t3_hex_edit", HEX, {7'h0E, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    press(1, 0);
    chk("t3_editing_off", EDITING, 1'b0);
    chk("t3_color", COLOR, 24'h123456);
    chk("t3_hex", HEX, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});

    // 4: simultaneous EDIT+NEXT at cursor 3 aborts
    press(1, 0);
    SW = 4'h7; press(0, 1); press(0, 1);
    chk("t4_hex_edit", HEX, {7'h78, 7'h78, 7'h30, 7'h19, 7'h12, 7'h02});
    SW = 4'h9; press(1, 1);
    chk("t4_editing_off", EDITING, 1'b0);
    chk("t4_color", COLOR, 24'h123456);
    chk("t4_hex", HEX, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});

    // 5: glitch ignored, long hold advances once
    press(1, 0);
    SW = 4'hA;
    @(negedge CLK); KEY_NEXT_N = 1'b0;
    repeat (DB - 1) @(negedge CLK);
    KEY_NEXT_N = 1'b1;
    repeat (DB + 6) @(negedge CLK);
    chk("t5_glitch", HEX, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    press(0, 1);
    chk("t5_write_d5", HEX, {7'h08, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    SW = 4'hB;
    @(negedge CLK); KEY_NEXT_N = 1'b0;
    repeat (10 * DB) @(negedge CLK);
    KEY_NEXT_N = 1'b1;
    repeat (DB + 6) @(negedge CLK);
    chk("t5_hold", HEX, {7'h08, 7'h03, 7'h30, 7'h19, 7'h12, 7'h02});
    SW = 4'hC; press(0, 1);
    chk("t5_next_d3", HEX, {7'h08, 7'h03, 7'h46, 7'h19, 7'h12, 7'h02});

    // 6: blink at cursor 2, then reset mid-edit
    tick(29);
    chk("t6_blink_on_29", HEX, {7'h08, 7'h03, 7'h46, 7'h19, 7'h12, 7'h02});
    tick(1);
    chk("t6_blink_off_30", HEX, {7'h08, 7'h03, 7'h46, 7'h7F, 7'h12, 7'h02});
    tick(29);
    chk("t6_blink_off_59", HEX, {7'h08, 7'h03, 7'h46, 7'h7F, 7'h12, 7'h02});
    tick(1);
    chk("t6_blink_on_60", HEX, {7'h08, 7'h03, 7'h46, 7'h19, 7'h12, 7'h02});
    chk("t6_swatch_committed", COLOR, 24'h123456);
    @(negedge CLK); {iR, iG, iB} = 24'h111111;
    repeat (2) @(negedge CLK);
    chk("t6_pre_rst_oRGB", {oR, oG, oB}, 24'h111111);
    RST_N = 1'b0;
    #1;
    chk("t6_rst_color", COLOR, 24'h0);
    chk("t6_rst_editing", EDITING, 1'b0);
    chk("t6_rst_hex", HEX, {6{7'h40}});
    chk("t6_rst_oRGB", {oR, oG, oB}, 24'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    press(1, 0);
    chk("t6_reedit_editing", EDITING, 1'b1);
    chk("t6_reedit_buf", HEX, {6{7'h40}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
